// File: rtl/mac_accum_pkg.sv
// Shared types and constants for the multiply-accumulate stage.
// Holds the FSM state type, default widths and the product sign-extension helper.
package mac_pkg;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int CNT_W_DEF  = 8;
    // Widest accumulator the sign-extension helper can serve.
    localparam int SEXT_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Sign-extend a pw-bit two's complement value (right-aligned in p) to SEXT_W bits.
    function automatic logic [SEXT_W-1:0] sext_prod(input logic [SEXT_W-1:0] p, input int pw);
        logic signed [SEXT_W-1:0] t;
        t = $signed(p << (SEXT_W - pw));
        return t >>> (SEXT_W - pw);
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// W-bit signed adder with overflow flag.
// With MAC_ACCUM_SAT_EN defined the result clamps to the signed range on overflow.
module mac_sat_add #(
    parameter int W = 40
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W-1:0] raw;

    assign raw   = a_i + b_i;
    assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);

`ifdef MAC_ACCUM_SAT_EN
    // Operands share a sign on overflow, so either one picks the clamp direction.
    logic [W-1:0] sat_val;
    assign sat_val = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign sum_o   = ovf_o ? sat_val : raw;
`else
    assign sum_o = raw;
`endif

endmodule

// File: rtl/mac_accum.sv
// Accumulates a programmed number of signed products and hands off the sum.
// Optional saturation on overflow is enabled by defining MAC_ACCUM_SAT_EN.
module mac_accum
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              p_valid_i,
    input  logic [PROD_W-1:0] p_i,
    output logic              p_ready_o,
    output logic              acc_valid_o,
    output logic [ACC_W-1:0]  acc_o,
    input  logic              acc_ready_i,
    output logic              ovf_o,
    output logic              busy_o
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, sum;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d, add_ovf;
    logic [SEXT_W-1:0]  p_ext;

    assign p_ext = sext_prod(SEXT_W'(p_i), PROD_W);

    generate
        if (ACC_W < SEXT_W) begin : g_sink
            logic unused_p_ext;
            assign unused_p_ext = ^p_ext[SEXT_W-1:ACC_W];
        end
    endgenerate

    mac_sat_add #(.W(ACC_W)) u_add (
        .a_i   (acc_q),
        .b_i   (p_ext[ACC_W-1:0]),
        .sum_o (sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len_i != '0) begin
                        cnt_d   = len_i;
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (p_valid_i && p_ready_o) begin
                    acc_d = sum;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (acc_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Every output comes straight from registered state; no input reaches an output combinationally.
    assign p_ready_o   = (state_q == ACCUM);
    assign acc_valid_o = (state_q == DONE);
    assign acc_o       = acc_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (state_q != IDLE);

endmodule
